// File: rtl/soc_event_queue_pkg.sv
// Shared defaults and the round-robin search used by the event queue arbiter.
package soc_event_queue_pkg;

    localparam int DEF_NB_SOURCES     = 8;
    localparam int DEF_EVENT_ID_WIDTH = 8;
    localparam int DEF_ID_OFFSET      = 0;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int MAX_SOURCES        = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } rr_grant_t;

    // Finds the first set bit of pend, starting at last+1 and wrapping modulo nb.
    // Scans from the farthest candidate to the nearest so the nearest set bit is
    // the last one written and therefore wins.
    function automatic rr_grant_t rr_next(input logic [MAX_SOURCES-1:0] pend,
                                          input logic [4:0]             last,
                                          input int                     nb);
        rr_grant_t g;
        int        cand;
        g = '0;
        for (int k = MAX_SOURCES; k >= 1; k--) begin
            if (k <= nb) begin
                cand = (int'(last) + k) % nb;
                if (pend[cand]) begin
                    g.valid = 1'b1;
                    g.idx   = 5'(cand);
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/soc_event_fifo.sv
// Synchronous FIFO with registered occupancy and a head-of-queue data output.
module soc_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (level != LW'(DEPTH));
    assign pop_ok  = pop_i && (level != '0);

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage write.
    // NOTE: the storage array is deliberately left out of reset; stale contents
    // are never visible because the head output is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

    assign valid_o = (level != '0);
    assign data_o  = valid_o ? mem[rd_ptr] : '0;
    assign level_o = level;

endmodule

// File: rtl/soc_event_queue.sv
// Collects per-source event pulses into one-deep pending flags and serialises
// them round-robin into a small FIFO of event IDs for the FC event port.
module soc_event_queue
    import soc_event_queue_pkg::*;
#(
    parameter int NB_SOURCES     = DEF_NB_SOURCES,
    parameter int EVENT_ID_WIDTH = DEF_EVENT_ID_WIDTH,
    parameter int ID_OFFSET      = DEF_ID_OFFSET,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_SOURCES-1:0]         events_i,
    output logic                          event_fifo_valid_o,
    input  logic                          event_fifo_fulln_i,
    output logic [EVENT_ID_WIDTH-1:0]     event_fifo_data_o,
    output logic [NB_SOURCES-1:0]         overflow_o,
    input  logic [NB_SOURCES-1:0]         overflow_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    if ((longint'(ID_OFFSET) + longint'(NB_SOURCES)) > (longint'(1) << EVENT_ID_WIDTH)) begin : g_id_range_check
        $error("soc_event_queue: ID_OFFSET + NB_SOURCES exceeds the event ID range");
    end

    logic [NB_SOURCES-1:0]     pend_q;
    logic [NB_SOURCES-1:0]     ovf_q;
    logic [4:0]                last_q;
    rr_grant_t                 grant;
    logic [NB_SOURCES-1:0]     gnt_vec;
    logic [EVENT_ID_WIDTH-1:0] push_id;
    logic [LW-1:0]             level;
    logic                      fifo_valid;
    logic                      pop;

    // Arbiter: one grant per cycle when something is pending and the FIFO has room.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant   = '0;
        gnt_vec = '0;
        if (level < LW'(FIFO_DEPTH)) begin
            grant = rr_next(MAX_SOURCES'(pend_q), last_q, NB_SOURCES);
        end
        for (int i = 0; i < NB_SOURCES; i++) begin
            gnt_vec[i] = grant.valid && (int'(grant.idx) == i);
        end
        push_id = EVENT_ID_WIDTH'(ID_OFFSET + int'(grant.idx));
    end

    // Pending flags, sticky overflow flags and the round-robin pointer.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            ovf_q  <= '0;
            last_q <= 5'(NB_SOURCES - 1);
        end else begin
            pend_q <= events_i | (pend_q & ~gnt_vec);
            ovf_q  <= (events_i & pend_q & ~gnt_vec) | (ovf_q & ~overflow_clr_i);
            if (grant.valid) last_q <= grant.idx;
        end
    end

    assign pop = fifo_valid && event_fifo_fulln_i;

    soc_event_fifo #(
        .WIDTH (EVENT_ID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant.valid),
        .data_i  (push_id),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (event_fifo_data_o),
        .level_o (level)
    );

    assign event_fifo_valid_o = fifo_valid;
    assign overflow_o         = ovf_q;
    assign level_o            = level;

endmodule

// File: tb/tb_soc_event_queue.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based behavioural model of the event queue.
module tb_soc_event_queue;

    localparam int NB     = 8;
    localparam int W      = 8;
    localparam int OFFSET = 16;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] events = '0;
    logic          fulln = 1'b0;
    logic [NB-1:0] clr = '0;
    logic          valid;
    logic [W-1:0]  data;
    logic [NB-1:0] ovf;
    logic [LW-1:0] level;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    soc_event_queue #(
        .NB_SOURCES     (NB),
        .EVENT_ID_WIDTH (W),
        .ID_OFFSET      (OFFSET),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .events_i           (events),
        .event_fifo_valid_o (valid),
        .event_fifo_fulln_i (fulln),
        .event_fifo_data_o  (data),
        .overflow_o         (ovf),
        .overflow_clr_i     (clr),
        .level_o            (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit [NB-1:0] m_pend;
    bit [NB-1:0] m_ovf;
    int          m_last;
    int          m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0;
            m_ovf  = '0;
            m_last = NB - 1;
            m_q.delete();
        end else begin
            int g;
            bit do_pop;
            g = -1;
            do_pop = (m_q.size() != 0) && fulln;
            if (m_q.size() < DEPTH) begin
                for (int k = 1; k <= NB; k++) begin
                    if (g < 0 && m_pend[(m_last + k) % NB]) g = (m_last + k) % NB;
                end
            end
            for (int i = 0; i < NB; i++) begin
                bit lost;
                lost = events[i] && m_pend[i] && (g != i);
                m_ovf[i]  = lost || (m_ovf[i] && !clr[i]);
                m_pend[i] = events[i] || (m_pend[i] && (g != i));
            end
            if (do_pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(OFFSET + g);
                m_last = g;
            end
        end
    end

    // Compare process: outputs against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_valid", 32'(valid), 32'(m_q.size() != 0));
            check("model_data", 32'(data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
            check("model_level", 32'(level), 32'(m_q.size()));
            check("model_overflow", 32'(ovf), 32'(m_ovf));
        end
    end

    // ---------------- directed helpers ----------------
    int got[$];

    // Called right after a falling edge; records every ID popped over 'cycles' cycles.
    task automatic collect(input int cycles);
        events = '0;
        fulln  = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (valid) got.push_back(int'(data));
            @(negedge clk);
        end
    endtask

    function automatic int count_id(input int id);
        int c;
        c = 0;
        foreach (got[i]) if (got[i] == id) c++;
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int bp_ids[6] = '{23, 16, 17, 18, 20, 21};
    int of_ids[5] = '{16, 17, 19, 20, 18};

    initial begin
        int vcount;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_overflow", 32'(ovf), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single event on source 3: valid exactly two cycles later with ID 19
        fulln = 1'b1;
        events = 8'h08;
        @(negedge clk); events = '0;
        check("single_valid_t1", 32'(valid), 32'd0);
        @(negedge clk);
        check("single_valid_t2", 32'(valid), 32'd1);
        check("single_data_t2", 32'(data), 32'd19);
        check("single_level_t2", 32'(level), 32'd1);
        @(negedge clk);
        check("single_valid_t3", 32'(valid), 32'd0);
        check("single_level_t3", 32'(level), 32'd0);

        // Round robin from reset: 16..23 on consecutive cycles
        do_reset();
        events = 8'hFF;
        @(negedge clk);
        got.delete();
        collect(9);
        check("rr1_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("rr1_id", 32'(got[i]), 32'(OFFSET + i));

        // Round robin with last=5: 22,23,16..21
        events = 8'h20;
        @(negedge clk);
        collect(4);
        got.delete();
        events = 8'hFF;
        @(negedge clk);
        collect(9);
        check("rr2_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("rr2_id", 32'(got[i]), 32'(OFFSET + (6 + i) % 8));

        // Backpressure: 6 sources while the consumer is stalled
        got.delete();
        fulln = 1'b0;
        events = 8'hB7;
        @(negedge clk); events = '0;
        repeat (6) @(negedge clk);
        check("bp_level_sat", 32'(level), 32'd4);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_head", 32'(data), 32'd23);
        @(negedge clk);
        check("bp_head_stable", 32'(data), 32'd23);
        collect(8);
        check("bp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("bp_id", 32'(got[i]), 32'(bp_ids[i]));
        check("bp_no_overflow", 32'(ovf), 32'd0);

        // Overflow on source 2 while full; clear vs set priority
        got.delete();
        fulln = 1'b0;
        events = 8'h1B;
        @(negedge clk); events = '0;
        repeat (5) @(negedge clk);
        events = 8'h04;
        @(negedge clk); events = '0;
        @(negedge clk); events = 8'h04;
        @(negedge clk); events = '0;
        check("ovf_set", 32'(ovf[2]), 32'd1);
        events = 8'h04; clr = 8'h04;
        @(negedge clk); events = '0; clr = '0;
        check("ovf_set_wins", 32'(ovf[2]), 32'd1);
        clr = 8'h04;
        @(negedge clk); clr = '0;
        check("ovf_cleared", 32'(ovf[2]), 32'd0);
        collect(8);
        check("ovf_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("ovf_id", 32'(got[i]), 32'(of_ids[i]));
        check("ovf_single_id2", 32'(count_id(18)), 32'd1);

        // Grant/pulse collision on source 1
        got.delete();
        events = 8'h02;
        @(negedge clk); events = 8'h02;
        @(negedge clk);
        collect(6);
        check("coll_count_id1", 32'(count_id(17)), 32'd2);
        check("coll_total", 32'(got.size()), 32'd2);
        check("coll_no_overflow", 32'(ovf[1]), 32'd0);

        // Reset mid-operation with queued entries and pending flags
        fulln = 1'b0;
        events = 8'h07;
        @(negedge clk); events = '0;
        repeat (4) @(negedge clk);
        check("mid_level_before", 32'(level), 32'd3);
        events = 8'h60;
        @(negedge clk); events = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_overflow", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fulln = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("mid_no_stale", 32'(vcount), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            events = NB'($urandom & $urandom);
            fulln  = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
            @(negedge clk);
        end
        events = '0;
        clr = '0;
        fulln = 1'b1;
        repeat (20) @(negedge clk);
        check("final_drained", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
